// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI responder backed by a word-addressed on-chip SRAM
//
// Purpose: answers the arbiter's AXI master port. Reads are 1 or 2 incrementing
// beats with a fixed programmable latency; writes are single-beat with byte strobes.
// The read and write channels run as independent FSMs and may overlap.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   axi_aw_*                 write address channel (ready out, valid/addr in)
//   axi_w_*                  write data channel (ready out, valid/data/strb in)
//   axi_b_*                  write response channel (valid/resp out, ready in)
//   axi_ar_*                 read address channel (ready out, valid/addr/len in)
//   axi_r_*                  read data channel (valid/resp/data/last out, ready in)

module axi_sram_slave #(
  parameter int unsigned                AXI_DATA_WIDTH = 64,
  parameter int unsigned                AXI_ADDR_WIDTH = 32,
  parameter int unsigned                DEPTH          = 256,
  parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = 32'h8000_0000,
  parameter int unsigned                RD_LATENCY     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          axi_aw_ready_o,
  input  logic                          axi_aw_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     axi_aw_addr_i,
  output logic                          axi_w_ready_o,
  input  logic                          axi_w_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]     axi_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   axi_w_strb_i,
  input  logic                          axi_b_ready_i,
  output logic                          axi_b_valid_o,
  output logic [1:0]                    axi_b_resp_o,
  output logic                          axi_ar_ready_o,
  input  logic                          axi_ar_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     axi_ar_addr_i,
  input  logic                          axi_ar_len_i,
  input  logic                          axi_r_ready_i,
  output logic                          axi_r_valid_o,
  output logic [1:0]                    axi_r_resp_o,
  output logic [AXI_DATA_WIDTH-1:0]     axi_r_data_o,
  output logic                          axi_r_last_o
);

  localparam int          IDX_W      = $clog2(DEPTH);
  localparam int          STRB_W     = AXI_DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLV   = 2'b10;
  localparam logic [3:0]  RD_LAT_L   = 4'(RD_LATENCY);
  localparam bit          RD_NO_WAIT = (RD_LATENCY == 0);

  // The offset test also rejects addresses below BASE_ADDR, because the
  // subtraction wraps to a huge value whose upper bits are non-zero.
  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> (IDX_W + 3)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------------------------------------------------------- read FSM
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;

  rd_state_e                  rd_state_q, rd_state_d;
  logic [AXI_ADDR_WIDTH-1:0]  rd_addr_q;
  logic                       rd_beats_q;
  logic [3:0]                 rd_cnt_q;
  logic [AXI_DATA_WIDTH-1:0]  r_data_q;
  logic [1:0]                 r_resp_q;
  logic                       r_last_q;

  logic                       ar_hs, r_hs;
  logic                       rd_load;
  logic [AXI_ADDR_WIDTH-1:0]  rd_load_addr;
  logic                       rd_load_last;

  assign ar_hs = axi_ar_valid_i & axi_ar_ready_o;
  assign r_hs  = axi_r_valid_o & axi_r_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE: if (ar_hs) rd_state_d = RD_NO_WAIT ? R_DATA : R_WAIT;
      R_WAIT: if (rd_cnt_q <= 4'd1) rd_state_d = R_DATA;
      R_DATA: if (r_hs && !rd_beats_q) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    axi_ar_ready_o = 1'b0;
    axi_r_valid_o  = 1'b0;
    case (rd_state_q)
      R_IDLE:  axi_ar_ready_o = 1'b1;
      R_DATA:  axi_r_valid_o  = 1'b1;
      default: ;
    endcase
  end

  // Beat-register load: on entry to R_DATA (straight from the AR handshake
  // when there is no latency) and when beat 1 of a 2-beat burst is accepted.
  always_comb begin
    rd_load      = 1'b0;
    rd_load_addr = rd_addr_q;
    rd_load_last = ~rd_beats_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs && RD_NO_WAIT) begin
          rd_load      = 1'b1;
          rd_load_addr = axi_ar_addr_i;
          rd_load_last = ~axi_ar_len_i;
        end
      end
      R_WAIT: rd_load = (rd_cnt_q <= 4'd1);
      R_DATA: begin
        if (r_hs && rd_beats_q) begin
          rd_load      = 1'b1;
          rd_load_addr = rd_addr_q + AXI_ADDR_WIDTH'(8);
          rd_load_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q  <= '0;
      rd_beats_q <= 1'b0;
      rd_cnt_q   <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
      r_last_q   <= 1'b0;
    end else begin
      if (rd_state_q == R_WAIT) rd_cnt_q <= rd_cnt_q - 4'd1;
      if (ar_hs) begin
        rd_addr_q  <= axi_ar_addr_i;
        rd_beats_q <= axi_ar_len_i;
        rd_cnt_q   <= RD_LAT_L;
      end
      if (rd_state_q == R_DATA && r_hs && rd_beats_q) begin
        rd_addr_q  <= rd_addr_q + AXI_ADDR_WIDTH'(8);
        rd_beats_q <= 1'b0;
      end
      // Nonblocking sample of mem_q: a same-edge write is not yet visible.
      if (rd_load) begin
        r_data_q <= in_range(rd_load_addr) ? mem_q[word_idx(rd_load_addr)] : '0;
        r_resp_q <= in_range(rd_load_addr) ? RESP_OKAY : RESP_SLV;
        r_last_q <= rd_load_last;
      end
    end
  end

  assign axi_r_data_o = r_data_q;
  assign axi_r_resp_o = r_resp_q;
  assign axi_r_last_o = r_last_q;

  // --------------------------------------------------------------- write FSM
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  wr_state_e                  wr_state_q, wr_state_d;
  logic [AXI_ADDR_WIDTH-1:0]  wr_addr_q;
  logic [1:0]                 b_resp_q;
  logic                       aw_hs, w_hs;

  assign aw_hs = axi_aw_valid_i & axi_aw_ready_o;
  assign w_hs  = axi_w_valid_i & axi_w_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_IDLE:  if (aw_hs) wr_state_d = W_DATA;
      W_DATA:  if (w_hs) wr_state_d = W_RESP;
      W_RESP:  if (axi_b_ready_i) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    axi_aw_ready_o = 1'b0;
    axi_w_ready_o  = 1'b0;
    axi_b_valid_o  = 1'b0;
    case (wr_state_q)
      W_IDLE:  axi_aw_ready_o = 1'b1;
      W_DATA:  axi_w_ready_o  = 1'b1;
      W_RESP:  axi_b_valid_o  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q <= '0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      if (aw_hs) wr_addr_q <= axi_aw_addr_i;
      if (w_hs)  b_resp_q  <= in_range(wr_addr_q) ? RESP_OKAY : RESP_SLV;
    end
  end

  assign axi_b_resp_o = b_resp_q;

  // Array is never reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_hs && in_range(wr_addr_q)) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (axi_w_strb_i[i]) mem_q[word_idx(wr_addr_q)][8*i +: 8] <= axi_w_data_i[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - self-checking bench for axi_sram_slave

module tb_axi_sram_slave;

  localparam int          DEPTH  = 256;
  localparam int          RD_LAT = 2;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        aw_ready, aw_valid;
  logic [31:0] aw_addr;
  logic        w_ready, w_valid;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_ready, b_valid;
  logic [1:0]  b_resp;
  logic        ar_ready, ar_valid;
  logic [31:0] ar_addr;
  logic        ar_len;
  logic        r_ready, r_valid;
  logic [1:0]  r_resp;
  logic [63:0] r_data;
  logic        r_last;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [DEPTH];

  axi_sram_slave #(
    .AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32), .DEPTH(DEPTH),
    .BASE_ADDR(BASE), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .axi_aw_ready_o(aw_ready), .axi_aw_valid_i(aw_valid), .axi_aw_addr_i(aw_addr),
    .axi_w_ready_o(w_ready), .axi_w_valid_i(w_valid), .axi_w_data_i(w_data), .axi_w_strb_i(w_strb),
    .axi_b_ready_i(b_ready), .axi_b_valid_o(b_valid), .axi_b_resp_o(b_resp),
    .axi_ar_ready_o(ar_ready), .axi_ar_valid_i(ar_valid), .axi_ar_addr_i(ar_addr), .axi_ar_len_i(ar_len),
    .axi_r_ready_i(r_ready), .axi_r_valid_o(r_valid), .axi_r_resp_o(r_resp),
    .axi_r_data_o(r_data), .axi_r_last_o(r_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_in_range(input logic [31:0] a);
    longint x, b;
    x = longint'({32'd0, a});
    b = longint'({32'd0, BASE});
    return (x >= b) && (x < b + DEPTH * 8);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    longint x, b;
    x = longint'({32'd0, a});
    b = longint'({32'd0, BASE});
    return int'((x - b) / 8);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    if (m_in_range(a)) begin
      for (int i = 0; i < 8; i++) begin
        if (s[i]) model[m_idx(a)][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return BASE - 32'(8 * $urandom_range(1, 4));
    if (r == 1) return BASE + 32'(DEPTH * 8) + 32'($urandom_range(0, 64));
    return BASE + 32'($urandom_range(0, DEPTH - 1) * 8) + 32'($urandom_range(0, 7));
  endfunction

  // Called at a negedge with the write channel idle.
  task automatic write_txn(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    int n;
    aw_valid = 1'b1; aw_addr = a;
    w_valid = 1'b1; w_data = d; w_strb = s;
    check("w_stall_before_aw", 64'(w_ready), 64'(0));
    n = 0;
    while (!aw_ready && n < 20) begin @(negedge clk); n++; end
    check("aw_timeout", 64'(n < 20), 64'(1));
    @(negedge clk);
    aw_valid = 1'b0;
    n = 0;
    while (!w_ready && n < 20) begin @(negedge clk); n++; end
    check("w_timeout", 64'(n < 20), 64'(1));
    @(negedge clk);
    w_valid = 1'b0;
    model_write(a, d, s);
    b_ready = 1'b1;
    n = 0;
    while (!b_valid && n < 20) begin @(negedge clk); n++; end
    check("b_timeout", 64'(n < 20), 64'(1));
    check("b_resp", 64'(b_resp), m_in_range(a) ? 64'(0) : 64'(2));
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  // Called at a negedge with the read channel idle.
  task automatic read_txn(input logic [31:0] a, input logic len, input int stall,
                          output logic [63:0] last_data);
    int          n;
    logic [31:0] ba;
    logic [63:0] ed;
    logic [1:0]  er;
    last_data = '0;
    r_ready = 1'b0;
    ar_valid = 1'b1; ar_addr = a; ar_len = len;
    n = 0;
    while (!ar_ready && n < 20) begin @(negedge clk); n++; end
    check("ar_timeout", 64'(n < 20), 64'(1));
    @(negedge clk);
    ar_valid = 1'b0;
    n = 1;
    while (!r_valid && n < 40) begin @(negedge clk); n++; end
    check("rd_latency", 64'(n), 64'(RD_LAT + 1));
    for (int k = 0; k <= int'(len); k++) begin
      ba = a + 32'(8 * k);
      if (m_in_range(ba)) begin ed = model[m_idx(ba)]; er = 2'b00; end
      else begin ed = '0; er = 2'b10; end
      if (k == 0) begin
        for (int s = 0; s < stall; s++) begin
          check("r_hold_valid", 64'(r_valid), 64'(1));
          check("r_hold_data", r_data, ed);
          check("r_hold_last", 64'(r_last), 64'(k == int'(len)));
          @(negedge clk);
        end
      end
      r_ready = 1'b1;
      check("r_valid", 64'(r_valid), 64'(1));
      check("r_data", r_data, ed);
      check("r_resp", 64'(r_resp), 64'(er));
      check("r_last", 64'(r_last), 64'(k == int'(len)));
      last_data = r_data;
      @(negedge clk);
      r_ready = 1'b0;
    end
    check("r_done_valid", 64'(r_valid), 64'(0));
    check("r_done_ar_ready", 64'(ar_ready), 64'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] got;
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    int          sel, n;

    rst = 1'b1;
    aw_valid = 1'b0; aw_addr = '0; w_valid = 1'b0; w_data = '0; w_strb = '0;
    b_ready = 1'b0; ar_valid = 1'b0; ar_addr = '0; ar_len = 1'b0; r_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_aw_ready", 64'(aw_ready), 64'(1));
    check("rst_ar_ready", 64'(ar_ready), 64'(1));
    check("rst_w_ready", 64'(w_ready), 64'(0));
    check("rst_b_valid", 64'(b_valid), 64'(0));
    check("rst_r_valid", 64'(r_valid), 64'(0));
    check("rst_r_last", 64'(r_last), 64'(0));
    check("rst_r_data", r_data, 64'(0));

    for (int i = 0; i < DEPTH; i++)
      write_txn(BASE + 32'(8 * i), {$urandom, $urandom}, 8'hFF);

    write_txn(32'h8000_0010, 64'h1122334455667788, 8'hFF);
    read_txn(32'h8000_0010, 1'b0, 0, got);
    check("t_basic_data", got, 64'h1122334455667788);

    write_txn(BASE + 32'h28, 64'h0, 8'hFF);
    write_txn(BASE + 32'h28, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    read_txn(BASE + 32'h28, 1'b0, 0, got);
    check("t_strb_low", got, 64'h0000_0000_FFFF_FFFF);

    write_txn(BASE, 64'hAAAA_0000_AAAA_0001, 8'hFF);
    write_txn(BASE + 32'h8, 64'hBBBB_0000_BBBB_0002, 8'hFF);
    read_txn(BASE, 1'b1, 3, got);
    check("t_burst_beat2", got, 64'hBBBB_0000_BBBB_0002);

    read_txn(BASE + 32'(8 * (DEPTH - 1)), 1'b1, 1, got);
    check("t_top_beat2_zero", got, 64'h0);

    write_txn(32'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    read_txn(BASE, 1'b0, 0, got);
    check("t_below_base_untouched", got, 64'hAAAA_0000_AAAA_0001);

    write_txn(BASE + 32'h30, 64'h1234_5678_9ABC_DEF0, 8'h00);
    read_txn(BASE + 32'h30, 1'b0, 0, got);

    fork
      write_txn(BASE + 32'h100, 64'h0F0F_0F0F_0F0F_0F0F, 8'hF0);
      read_txn(BASE + 32'h200, 1'b1, 2, got);
    join

    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      a = rand_addr();
      if (sel < 4) begin
        d = {$urandom, $urandom};
        s = 8'($urandom);
        if (sel == 0) s = 8'h00;
        write_txn(a, d, s);
      end else begin
        read_txn(a, 1'($urandom), $urandom_range(0, 3), got);
      end
    end

    // Reset while the read channel is waiting out its latency.
    ar_valid = 1'b1; ar_addr = BASE + 32'h40; ar_len = 1'b1;
    @(negedge clk);
    ar_valid = 1'b0;
    do_reset();
    check("rst_rwait_r_valid", 64'(r_valid), 64'(0));
    check("rst_rwait_ar_ready", 64'(ar_ready), 64'(1));
    repeat (RD_LAT + 3) @(negedge clk);
    check("rst_rwait_no_resp", 64'(r_valid), 64'(0));

    // Reset while the write response is pending and b_ready is low.
    aw_valid = 1'b1; aw_addr = BASE + 32'h48;
    w_valid = 1'b1; w_data = 64'hCAFE_F00D_CAFE_F00D; w_strb = 8'hFF;
    @(negedge clk);
    aw_valid = 1'b0;
    n = 0;
    while (!w_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    w_valid = 1'b0;
    model_write(BASE + 32'h48, 64'hCAFE_F00D_CAFE_F00D, 8'hFF);
    check("wresp_b_valid", 64'(b_valid), 64'(1));
    do_reset();
    check("rst_wresp_b_valid", 64'(b_valid), 64'(0));
    check("rst_wresp_aw_ready", 64'(aw_ready), 64'(1));
    check("rst_wresp_w_ready", 64'(w_ready), 64'(0));
    check("rst_wresp_r_valid", 64'(r_valid), 64'(0));
    read_txn(BASE + 32'h48, 1'b0, 0, got);
    check("t_after_reset_data", got, 64'hCAFE_F00D_CAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
